// File: rtl/led_pattern_if.sv
// Pattern-generator control/observe bundle: mode/hold in, LED drive and step tick out.
interface led_pattern_if #(
  parameter int unsigned NUM_LEDS = 4
);
  logic [1:0]          mode;
  logic                hold;
  logic [NUM_LEDS-1:0] leds;
  logic                tick;

  modport master (output mode, hold, input leds, tick);
  modport slave  (input mode, hold, output leds, tick);
endinterface

// File: rtl/led_pattern_gen.sv
// Runtime-selectable LED pattern generator: alternate, bounce chase, binary count, PWM breathe.
module led_pattern_gen #(
  parameter int unsigned NUM_LEDS = 4,
  parameter int unsigned STEP_DIV = 12000000,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic           clk,
  input  logic           rst,
  led_pattern_if.slave   bus
);

  localparam int unsigned PRESC_W = $clog2(STEP_DIV);
  localparam int unsigned POS_W   = $clog2(NUM_LEDS);

  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [NUM_LEDS-1:0] alt_init();
    logic [NUM_LEDS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i += 2) v[i] = 1'b1;
    return v;
  endfunction

  logic [PRESC_W-1:0]  presc, presc_n;
  logic [1:0]          mode_q;
  logic                started;
  logic [NUM_LEDS-1:0] pat, pat_n;
  logic [POS_W-1:0]    pos, pos_n;
  logic                dir, dir_n;
  logic [NUM_LEDS-1:0] cnt, cnt_n;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] leds_n, leds_q;
  logic                chg, load;
  logic                step_p0, step_p1, tick_p2;

  // Reset release is treated like a mode change so the first edge loads init state.
  assign chg  = (bus.mode != mode_q);
  assign load = chg || !started;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc   <= '0;
      mode_q  <= '0;
      started <= 1'b0;
      pat     <= '0;
      pos     <= '0;
      dir     <= DIR_UP;
      cnt     <= '0;
      duty    <= '0;
      pwm_cnt <= '0;
      leds_q  <= '0;
      step_p1 <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      presc   <= presc_n;
      mode_q  <= bus.mode;
      started <= 1'b1;
      pat     <= pat_n;
      pos     <= pos_n;
      dir     <= dir_n;
      cnt     <= cnt_n;
      duty    <= duty_n;
      pwm_cnt <= pwm_cnt + 1'b1;
      leds_q  <= leds_n;
      step_p1 <= step_p0;
      tick_p2 <= step_p1;
    end
  end

  always_comb begin
    presc_n = presc;
    pat_n   = pat;
    pos_n   = pos;
    dir_n   = dir;
    cnt_n   = cnt;
    duty_n  = duty;
    step_p0 = 1'b0;
    if (load) begin
      // Inactive modes' state is don't-care, so every mode's init is loaded together.
      presc_n = '0;
      pat_n   = alt_init();
      pos_n   = '0;
      dir_n   = DIR_UP;
      cnt_n   = '0;
      duty_n  = '0;
    end else if (bus.hold) begin
      presc_n = presc;
    end else if (presc == PRESC_LAST) begin
      presc_n = '0;
      step_p0 = 1'b1;
      case (mode_q)
        2'd0: pat_n = ~pat;
        2'd1: begin
          if (dir == DIR_UP) begin
            if (pos == POS_LAST) begin
              dir_n = DIR_DOWN;
              pos_n = POS_LAST - 1'b1;
            end else begin
              pos_n = pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              dir_n = DIR_UP;
              pos_n = POS_W'(1);
            end else begin
              pos_n = pos - 1'b1;
            end
          end
        end
        2'd2: cnt_n = cnt + 1'b1;
        default: begin
          if (dir == DIR_UP) begin
            if (duty == DUTY_MAX) begin
              dir_n  = DIR_DOWN;
              duty_n = DUTY_MAX - 1'b1;
            end else begin
              duty_n = duty + 1'b1;
            end
          end else begin
            if (duty == '0) begin
              dir_n  = DIR_UP;
              duty_n = PWM_BITS'(1);
            end else begin
              duty_n = duty - 1'b1;
            end
          end
        end
      endcase
    end else begin
      presc_n = presc + 1'b1;
    end
  end

  // Output stage: LED image formed from current state, registered one edge later.
  always_comb begin
    leds_n = '0;
    case (mode_q)
      2'd0:    leds_n = pat;
      2'd1:    leds_n = NUM_LEDS'(1) << pos;
      2'd2:    leds_n = cnt;
      default: leds_n = {NUM_LEDS{pwm_cnt < duty}};
    endcase
  end

  assign bus.leds = leds_q;
  assign bus.tick = tick_p2;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a per-cycle expected-output scoreboard.
module tb_led_pattern_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_pattern_if #(.NUM_LEDS(4)) bus ();

  led_pattern_gen #(.NUM_LEDS(4), .STEP_DIV(4), .PWM_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] leds;
    logic       tick;
    string      tag;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      checks++;
      assert ({bus.leds, bus.tick} === {got.leds, got.tick}) else begin
        errors++;
        $error("FAIL %s leds=%b tick=%b expected leds=%b tick=%b",
               got.tag, bus.leds, bus.tick, got.leds, got.tick);
      end
    end
  end

  task automatic cyc(input logic [3:0] l, input logic t, input string tag);
    exp_t e;
    e.leds = l;
    e.tick = t;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #3;
  endtask

  task automatic show(input logic [3:0] v, input logic t, input string tag);
    cyc(v, t, tag);
    repeat (3) cyc(v, 1'b0, tag);
  endtask

  task automatic show_hold(input logic [3:0] v, input string tag);
    cyc(v, 1'b1, tag);
    bus.hold = 1'b1;
    repeat (10) cyc(v, 1'b0, tag);
    bus.hold = 1'b0;
    repeat (3) cyc(v, 1'b0, tag);
  endtask

  task automatic window(input int duty, input string tag);
    int hi = 0;
    int tk = 0;
    repeat (8) begin
      @(posedge clk);
      #3;
      checks++;
      assert (bus.leds === 4'b0000 || bus.leds === 4'b1111) else begin
        errors++;
        $error("FAIL %s_uniform leds=%b expected all-equal bits", tag, bus.leds);
      end
      if (bus.leds[0] === 1'b1) hi++;
      if (bus.tick === 1'b1) tk++;
    end
    checks++;
    assert (hi === duty) else begin
      errors++;
      $error("FAIL %s_on_count got=%0d expected=%0d", tag, hi, duty);
    end
    checks++;
    assert (tk === 0) else begin
      errors++;
      $error("FAIL %s_hold_ticks got=%0d expected=0", tag, tk);
    end
  endtask

  task automatic wait_ticks(input int n, input string tag);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 200) begin
      @(posedge clk);
      #3;
      budget++;
      if (bus.tick === 1'b1) seen++;
    end
    checks++;
    assert (seen === n) else begin
      errors++;
      $error("FAIL %s_ticks got=%0d expected=%0d", tag, seen, n);
    end
  endtask

  initial begin
    bus.mode = 2'd0;
    bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    assert (bus.leds === 4'b0000) else begin
      errors++;
      $error("FAIL reset_leds got=%b expected=0000", bus.leds);
    end
    checks++;
    assert (bus.tick === 1'b0) else begin
      errors++;
      $error("FAIL reset_tick got=%b expected=0", bus.tick);
    end

    // Alternate mode from reset release
    rst = 1'b0;
    cyc(4'b0000, 1'b0, "alt_release");
    show(4'b0101, 1'b0, "alt_init");
    show(4'b1010, 1'b1, "alt_s1");
    show(4'b0101, 1'b1, "alt_s2");
    show(4'b1010, 1'b1, "alt_s3");
    show(4'b0101, 1'b1, "alt_s4");

    // Chase: bounce without repeating the end LEDs
    bus.mode = 2'd1;
    cyc(4'b1010, 1'b1, "alt_to_chase");
    show(4'b0001, 1'b0, "chase_init");
    show(4'b0010, 1'b1, "chase_1");
    show(4'b0100, 1'b1, "chase_2");
    show(4'b1000, 1'b1, "chase_3");
    show(4'b0100, 1'b1, "chase_4");
    show(4'b0010, 1'b1, "chase_5");
    show(4'b0001, 1'b1, "chase_6");
    show(4'b0010, 1'b1, "chase_7");

    // Binary count with wrap, then hold mid-period
    bus.mode = 2'd2;
    cyc(4'b0100, 1'b1, "chase_to_bin");
    show(4'b0000, 1'b0, "bin_init");
    for (int i = 1; i <= 17; i++) show(4'(i), 1'b1, "bin_count");
    show_hold(4'b0010, "bin_hold");

    // Mode change on the terminal prescaler cycle: load wins, no step
    cyc(4'b0011, 1'b1, "bin_3");
    cyc(4'b0011, 1'b0, "bin_3");
    cyc(4'b0011, 1'b0, "bin_3");
    bus.mode = 2'd0;
    cyc(4'b0011, 1'b0, "chg_wins");
    show(4'b0101, 1'b0, "chg_alt_init");
    show(4'b1010, 1'b1, "chg_alt_s1");

    // Breathe with PWM_BITS=3: freeze duty with hold and count on-cycles over a PWM period
    bus.mode = 2'd3;
    cyc(4'b0101, 1'b1, "alt_to_breathe");
    bus.hold = 1'b1;
    window(0, "duty0");
    bus.hold = 1'b0;
    wait_ticks(3, "ramp3");
    bus.hold = 1'b1;
    window(3, "duty3");
    bus.hold = 1'b0;
    wait_ticks(4, "ramp7");
    bus.hold = 1'b1;
    window(7, "duty7");
    bus.hold = 1'b0;
    wait_ticks(7, "ramp_down0");
    bus.hold = 1'b1;
    window(0, "duty0_down");
    bus.hold = 1'b0;
    wait_ticks(1, "ramp_up1");
    bus.hold = 1'b1;
    window(1, "duty1");
    bus.hold = 1'b0;

    // Asynchronous reset on a tick cycle
    bus.mode = 2'd0;
    wait_ticks(1, "pre_rst");
    checks++;
    assert (bus.leds === 4'b1010) else begin
      errors++;
      $error("FAIL pre_rst_leds got=%b expected=1010", bus.leds);
    end
    rst = 1'b1;
    #1;
    checks++;
    assert (bus.leds === 4'b0000) else begin
      errors++;
      $error("FAIL async_rst_leds got=%b expected=0000", bus.leds);
    end
    checks++;
    assert (bus.tick === 1'b0) else begin
      errors++;
      $error("FAIL async_rst_tick got=%b expected=0", bus.tick);
    end
    @(posedge clk);
    #3;
    rst = 1'b0;
    cyc(4'b0000, 1'b0, "rst2_release");
    show(4'b0101, 1'b0, "rst2_init");
    cyc(4'b1010, 1'b1, "rst2_s1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator; successor to the fixed 4-LED alternating blinker.
- Drives NUM_LEDS board LEDs in one of four runtime-selectable modes: alternate, bounce chase, binary count, PWM breathe.
- Step rate set by an internal prescaler. Supports freeze (hold) and a per-step tick for other blocks.
- Sits at the top level between the board clock and the LED pins.

Parameters:
NUM_LEDS, 4, number of LED outputs (legal range 2..32)
STEP_DIV, 12000000, clk cycles per pattern step (legal range 2..2^31)
PWM_BITS, 8, breathe-mode duty/PWM counter width (legal range 2..16)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
mode  input  2  pattern select: 0 alternate, 1 chase, 2 binary, 3 breathe; synchronous to clk
hold  input  1  1 = freeze prescaler and pattern state
leds  output  NUM_LEDS  LED drive, 1 = on, registered
tick  output  1  one-cycle pulse marking the first cycle leds shows a new step value

Behaviour:
- Reset: asynchronous, active-high, all registers cleared on assertion.
  - presc=0, mode_q=0, pat=0, pos=0, dir=up, cnt=0, duty=0, pwm_cnt=0, leds=0, tick=0.
  - Initial pattern values are loaded on the first clock edge after release (see mode change).
- Mode register mode_q <= mode every cycle. Define chg = (mode != mode_q).
- Reset release: treated as a mode change. The first edge after release loads the init state for the current mode.
- Prescaler presc, width clog2(STEP_DIV). Priority order:
  - chg or first post-reset cycle: presc <= 0, and the pattern state for the new mode loads its init.
  - else hold: all state holds.
  - else presc == STEP_DIV-1: presc <= 0, step = 1.
  - else presc <= presc+1.
- On step, update the active mode state. Other modes' state is don't-care.
  - Alternate: init pat = even bits 1 (…0101). Step: pat <= ~pat.
  - Chase: init pos=0, dir=up.
    - Up: pos==NUM_LEDS-1 -> dir=down, pos=NUM_LEDS-2; else pos+1.
    - Down: pos==0 -> dir=up, pos=1; else pos-1.
    - Each end LED is shown once per bounce, never twice in a row.
  - Binary: init cnt=0. Step: cnt+1, wrapping modulo 2^NUM_LEDS.
  - Breathe: init duty=0, dir=up.
    - Up: duty==2^PWM_BITS-1 -> dir=down, duty=max-1; else duty+1.
    - Down: duty==0 -> dir=up, duty=1; else duty-1.
- pwm_cnt (PWM_BITS wide) free-runs +1 every cycle. It ignores hold and chg, and wraps.
- leds is registered from the current state; it changes one edge after the state changes.
  - Alternate: leds = pat.
  - Chase: leds = one-hot(pos).
  - Binary: leds = cnt.
  - Breathe: all bits = (pwm_cnt < duty). duty=0 gives fully off; duty=max gives on for max of 2^PWM_BITS cycles.
- tick: step delayed two cycles (registered twice), so it is high exactly in the first cycle leds shows the stepped value. It is never asserted on a mode-change load. hold=1 suppresses all ticks.
- Simultaneous chg and presc==STEP_DIV-1: chg wins, no step, no tick.
- hold asserted mid-period: presc resumes from the held value on release; no phase loss.
- Reset asserted mid-operation: leds and tick go to 0 immediately (asynchronously).

Test Plan:
- NUM_LEDS=4, STEP_DIV=4, mode=0, release rst -> leds=0101 from cycle 2; first tick then leds=1010 at cycle 6; toggles every 4 cycles thereafter.
- mode=1, same params -> leds sequence 0001,0010,0100,1000,0100,0010,0001,0010, each held 4 cycles, one tick per change.
- mode=2 held for 17 steps -> leds counts 0000..1111 then wraps to 0000 and 0001; tick count = 17.
- mode=3, PWM_BITS=3 -> duty ramps 0..7..0. At duty=3, leds high 3 of every 8 cycles. At duty=0 never high; at duty=7 high 7 of 8.
- hold=1 for 10 cycles mid-period in mode 2 -> leds and presc frozen, no tick; the next step occurs exactly 10 cycles later than without hold.
- Change mode 2->0 on the same cycle presc==3 -> no tick, leds=0101 two edges later, next tick 4 cycles after the load. Async rst pulse mid-run -> leds=0 and tick=0 without a clock edge.
